// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters with round-robin priority.
// One operation is in flight at a time: IDLE accepts, EXEC drives the ALU, RESP returns the result.
module alu_share_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  input  logic [63:0] req_imm_val,
  input  logic [1:0]  req_imm,
  input  logic [5:0]  req_funct3,
  input  logic [13:0] req_funct7,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] alu_reg_source1,
  output logic [31:0] alu_reg_source2,
  output logic [31:0] alu_imm_source,
  output logic        alu_imm,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  input  logic [31:0] alu_res,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       prio;
  logic       owner;
  logic       grant;
  logic       grant_valid;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant       = prio;
    grant_valid = 1'b0;
    if (req_valid[prio]) begin
      grant       = prio;
      grant_valid = 1'b1;
    end else if (req_valid[~prio]) begin
      grant       = ~prio;
      grant_valid = 1'b1;
    end
  end

  // req_ready is forced low while reset is held so a waiting requester is never told it was accepted.
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && rst_n && grant_valid) req_ready[grant] = 1'b1;
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      prio            <= RR_INIT;
      owner           <= 1'b0;
      alu_reg_source1 <= '0;
      alu_reg_source2 <= '0;
      alu_imm_source  <= '0;
      alu_imm         <= 1'b0;
      alu_funct3      <= '0;
      alu_funct7      <= '0;
      rsp_data        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            alu_reg_source1 <= grant ? req_src1[63:32]    : req_src1[31:0];
            alu_reg_source2 <= grant ? req_src2[63:32]    : req_src2[31:0];
            alu_imm_source  <= grant ? req_imm_val[63:32] : req_imm_val[31:0];
            alu_imm         <= req_imm[grant];
            alu_funct3      <= grant ? req_funct3[5:3]    : req_funct3[2:0];
            alu_funct7      <= grant ? req_funct7[13:7]   : req_funct7[6:0];
            owner           <= grant;
            prio            <= ~grant;
            state           <= EXEC;
          end
        end
        EXEC: begin
          rsp_data <= alu_res;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU hooked to the alu_* port.
// Inputs change and outputs are sampled just after the falling edge.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_src1;
  logic [63:0] req_src2;
  logic [63:0] req_imm_val;
  logic [1:0]  req_imm;
  logic [5:0]  req_funct3;
  logic [13:0] req_funct7;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] alu_reg_source1;
  logic [31:0] alu_reg_source2;
  logic [31:0] alu_imm_source;
  logic        alu_imm;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_res;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_share_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_imm_val(req_imm_val),
    .req_imm(req_imm), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_reg_source1(alu_reg_source1), .alu_reg_source2(alu_reg_source2),
    .alu_imm_source(alu_imm_source), .alu_imm(alu_imm),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_res(alu_res), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: ADD/SUB, XOR, OR, AND.
  logic [31:0] alu_b;
  always_comb begin
    alu_b   = alu_imm ? alu_imm_source : alu_reg_source2;
    alu_res = alu_reg_source1 + alu_b;
    case (alu_funct3)
      3'd0: alu_res = (alu_funct7[5] && !alu_imm) ? alu_reg_source1 - alu_b
                                                   : alu_reg_source1 + alu_b;
      3'd4: alu_res = alu_reg_source1 ^ alu_b;
      3'd6: alu_res = alu_reg_source1 | alu_b;
      3'd7: alu_res = alu_reg_source1 & alu_b;
      default: alu_res = alu_reg_source1 + alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_req(input int i, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] iv, input logic im,
                           input logic [2:0] f3, input logic [6:0] f7);
    req_src1[i*32 +: 32]    = s1;
    req_src2[i*32 +: 32]    = s2;
    req_imm_val[i*32 +: 32] = iv;
    req_imm[i]              = im;
    req_funct3[i*3 +: 3]    = f3;
    req_funct7[i*7 +: 7]    = f7;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int got;
  int exp_owner;
  int hs_cyc[$];
  int rs_idx;
  int op_idx;
  logic pend;
  logic [31:0] thr_a [4];
  logic [31:0] thr_b [4];
  logic [6:0]  thr_f7 [4];
  logic [31:0] thr_exp [4];

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    req_src1 = '0; req_src2 = '0; req_imm_val = '0; req_imm = '0;
    req_funct3 = '0; req_funct7 = '0;

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_alu_src1", alu_reg_source1, 0);
    req_valid = 2'b11;
    #1 check("rst_req_ready", req_ready, 0);
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;

    // Single request: 5 + 3
    @(negedge clk);
    drive_req(0, 32'd5, 32'd3, 32'd0, 1'b0, 3'd0, 7'h00);
    req_valid = 2'b01; rsp_ready = 2'b11;
    #1 check("single_ready", req_ready, 2'b01);
    check("single_busy_n", busy, 0);
    @(negedge clk); req_valid = 2'b00;
    #1 check("single_funct3", alu_funct3, 3'd0);
    check("single_src1", alu_reg_source1, 32'd5);
    check("single_busy_n1", busy, 1);
    check("single_ready_exec", req_ready, 0);
    check("single_rsp_exec", rsp_valid, 0);
    @(negedge clk); #1;
    check("single_rsp_valid", rsp_valid, 2'b01);
    check("single_rsp_data", rsp_data, 32'd8);
    check("single_busy_n2", busy, 1);
    @(negedge clk); #1;
    check("single_idle", busy, 0);
    check("single_rsp_done", rsp_valid, 0);

    // Immediate path from requester 1
    @(negedge clk);
    drive_req(1, 32'hFFFF_FFF0, 32'h0000_1234, 32'h10, 1'b1, 3'd0, 7'h00);
    req_valid = 2'b10;
    #1 check("imm_ready", req_ready, 2'b10);
    @(negedge clk); req_valid = 2'b00;
    #1 check("imm_alu_imm", alu_imm, 1);
    check("imm_alu_imm_src", alu_imm_source, 32'h10);
    @(negedge clk); #1;
    check("imm_rsp_valid", rsp_valid, 2'b10);
    check("imm_rsp_data", rsp_data, 32'h0);
    @(negedge clk); #1 check("imm_idle", busy, 0);

    // Contention: both valid, expect 0,1,0,1
    @(negedge clk);
    drive_req(0, 32'd10, 32'd4, 32'd0, 1'b0, 3'd0, 7'h20);
    drive_req(1, 32'hF0, 32'h0F, 32'd0, 1'b0, 3'd4, 7'h00);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_owner = k % 2;
      got = 0;
      for (int w = 0; w < 6 && got == 0; w++) begin
        if (w != 0 || k != 0) @(negedge clk);
        #1 check("cont_not_both", (req_ready == 2'b11) ? 32'd1 : 32'd0, 0);
        if (req_ready != 2'b00) got = 1;
      end
      check("cont_granted", got, 1);
      check("cont_grant", req_ready, (exp_owner == 1) ? 2'b10 : 2'b01);
      @(negedge clk); @(negedge clk); #1;
      check("cont_rsp_valid", rsp_valid, (exp_owner == 1) ? 2'b10 : 2'b01);
      check("cont_rsp_data", rsp_data, (exp_owner == 1) ? 32'hFF : 32'd6);
      if (k == 3) req_valid = 2'b00;
    end
    @(negedge clk); #1 check("cont_idle", busy, 0);

    // Backpressure on requester 0, requester 1 waits
    @(negedge clk);
    drive_req(0, 32'd7, 32'd9, 32'd0, 1'b0, 3'd0, 7'h00);
    req_valid = 2'b01; rsp_ready = 2'b00;
    #1 check("bp_ready", req_ready, 2'b01);
    @(negedge clk);
    drive_req(1, 32'hA0, 32'h05, 32'd0, 1'b0, 3'd6, 7'h00);
    req_valid = 2'b10; rsp_ready = 2'b10;
    #1 check("bp_exec_ready", req_ready, 2'b00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("bp_hold_valid", rsp_valid, 2'b01);
      check("bp_hold_data", rsp_data, 32'd16);
      check("bp_hold_ready", req_ready, 2'b00);
    end
    @(negedge clk); rsp_ready = 2'b01;
    #1 check("bp_done_valid", rsp_valid, 2'b01);
    check("bp_done_no_accept", req_ready, 2'b00);
    @(negedge clk); rsp_ready = 2'b11;
    #1 check("bp_back_idle", busy, 0);
    check("bp_next_grant", req_ready, 2'b10);
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    check("bp_r1_valid", rsp_valid, 2'b10);
    check("bp_r1_data", rsp_data, 32'hA5);
    @(negedge clk); #1 check("bp_r1_idle", busy, 0);

    // Reset during EXEC
    @(negedge clk);
    drive_req(0, 32'hF, 32'h3, 32'd0, 1'b0, 3'd7, 7'h00);
    req_valid = 2'b01;
    #1 check("mrst_ready", req_ready, 2'b01);
    @(negedge clk); req_valid = 2'b00;
    #1 check("mrst_exec_busy", busy, 1);
    check("mrst_exec_f3", alu_funct3, 3'd7);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_rsp_valid", rsp_valid, 0);
    check("mrst_rsp_data", rsp_data, 0);
    check("mrst_alu_src1", alu_reg_source1, 0);
    check("mrst_alu_f3", alu_funct3, 0);
    req_valid = 2'b11;
    #1 check("mrst_req_ready", req_ready, 0);
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("mrst_no_rsp", rsp_valid, 0);
      check("mrst_no_busy", busy, 0);
    end
    @(negedge clk);
    drive_req(0, 32'd20, 32'd22, 32'd0, 1'b0, 3'd0, 7'h00);
    drive_req(1, 32'd1, 32'd1, 32'd0, 1'b0, 3'd0, 7'h00);
    req_valid = 2'b11;
    #1 check("mrst_prio_init", req_ready, 2'b01);
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    check("mrst_post_valid", rsp_valid, 2'b01);
    check("mrst_post_data", rsp_data, 32'd42);
    @(negedge clk); #1 check("mrst_post_idle", busy, 0);

    // Throughput: four back-to-back operations from requester 0
    thr_a   = '{32'd1, 32'd2, 32'd3, 32'd100};
    thr_b   = '{32'd1, 32'd2, 32'd3, 32'd1};
    thr_f7  = '{7'h00, 7'h00, 7'h00, 7'h20};
    thr_exp = '{32'd2, 32'd4, 32'd6, 32'd99};
    rs_idx = 0; op_idx = 0; pend = 1'b0;
    @(negedge clk);
    drive_req(0, thr_a[0], thr_b[0], 32'd0, 1'b0, 3'd0, thr_f7[0]);
    req_valid = 2'b01;
    for (int k = 0; k < 20; k++) begin
      if (k != 0) @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        op_idx++;
        if (op_idx < 4) drive_req(0, thr_a[op_idx], thr_b[op_idx], 32'd0, 1'b0, 3'd0, thr_f7[op_idx]);
        else req_valid = 2'b00;
      end
      #1;
      if (req_ready[0]) begin
        hs_cyc.push_back(k);
        pend = 1'b1;
      end
      if (rsp_valid[0]) begin
        check("thr_data", rsp_data, (rs_idx < 4) ? thr_exp[rs_idx] : 32'hDEAD_BEEF);
        rs_idx++;
      end
    end
    check("thr_rsp_count", rs_idx, 4);
    check("thr_hs_count", hs_cyc.size(), 4);
    for (int i = 1; i < hs_cyc.size(); i++)
      check("thr_hs_gap", hs_cyc[i] - hs_cyc[i-1], 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
